// File: rtl/pep_common_param_pkg.sv
// Global PBS batch and LWE parameters shared across the PEP pipeline.
package pep_common_param_pkg;
    localparam int BATCH_PBS_NB   = 4;
    localparam int BPBS_ID_W      = $clog2(BATCH_PBS_NB);
    localparam int LWE_K_P1       = 8;
    localparam int LWE_COEF_W     = 16;
    localparam int KS_MAX_ERROR_W = 8;
endpackage

// File: rtl/pep_ks_common_param_pkg.sv
// Key-switch result record and batch-pointer helpers.
package pep_ks_common_param_pkg;
    import pep_common_param_pkg::*;

    localparam int KS_LOOP_W  = $clog2(LWE_K_P1);
    // Batch pointers carry one extra wrap bit so full and empty differ.
    localparam int BPBS_PTR_W = BPBS_ID_W + 1;

    typedef struct packed {
        logic [KS_LOOP_W-1:0]                          ks_loop;
        logic [BPBS_PTR_W-1:0]                         wp;
        logic [BPBS_PTR_W-1:0]                         rp;
        logic [BATCH_PBS_NB-1:0][LWE_COEF_W-1:0]       lwe_a;
        logic [BATCH_PBS_NB-1:0][KS_MAX_ERROR_W-1:0]   corr_a;
    } ks_result_t;

    localparam int KS_RESULT_W = $bits(ks_result_t);

    function automatic logic [BPBS_PTR_W-1:0] pt_elt_nb(input logic [BPBS_PTR_W-1:0] wp,
                                                        input logic [BPBS_PTR_W-1:0] rp);
        return wp - rp;
    endfunction
endpackage

// File: rtl/pep_ks_result_dispatch_fifo_element.sv
// Small register-based skid FIFO with combinational head output.
module fifo_element #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_rdy   = s_rst_n && (count_reg != CNT_W'(DEPTH));
    assign out_vld  = (count_reg != '0);
    assign out_data = mem[rd_ptr_reg];
    assign push     = in_vld & in_rdy;
    assign pop      = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage is deliberately left out of reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) mem[gi] <= in_data;
        end
    end
endmodule

// File: rtl/pep_ks_result_dispatch.sv
// Serialises buffered key-switch results into one LWE coefficient per cycle.
module pep_ks_result_dispatch
    import pep_common_param_pkg::*;
    import pep_ks_common_param_pkg::*;
#(
    parameter int IN_FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      s_rst_n,
    input  logic [KS_RESULT_W-1:0]    ks_seq_result,
    input  logic                      ks_seq_result_vld,
    output logic                      ks_seq_result_rdy,
    input  logic                      reset_cache,
    output logic [LWE_COEF_W-1:0]     ks_coef_lwe,
    output logic [KS_MAX_ERROR_W-1:0] ks_coef_corr,
    output logic [KS_LOOP_W-1:0]      ks_coef_idx,
    output logic [BPBS_ID_W-1:0]      ks_coef_pid,
    output logic                      ks_coef_last,
    output logic                      ks_coef_body,
    output logic                      ks_coef_vld,
    input  logic                      ks_coef_rdy,
    output logic                      ks_batch_done
);
    logic [KS_RESULT_W-1:0] fifo_out;
    ks_result_t             fifo_data;
    logic                   fifo_vld, fifo_rdy;

    ks_result_t             work_data_reg;
    logic                   work_vld_reg;
    logic [BPBS_ID_W-1:0]   elt_reg;
    logic                   reset_loop_reg;
    logic                   done_reg;

    logic [BPBS_PTR_W-1:0]  work_n, fifo_n, pid_sum;
    logic                   accept, last_acc, load;

    fifo_element #(
        .WIDTH (KS_RESULT_W),
        .DEPTH (IN_FIFO_DEPTH)
    ) u_in_fifo (
        .clk      (clk),
        .s_rst_n  (s_rst_n),
        .in_data  (ks_seq_result),
        .in_vld   (ks_seq_result_vld),
        .in_rdy   (ks_seq_result_rdy),
        .out_data (fifo_out),
        .out_vld  (fifo_vld),
        .out_rdy  (fifo_rdy)
    );

    assign fifo_data = fifo_out;
    assign fifo_n    = pt_elt_nb(fifo_data.wp, fifo_data.rp);
    assign work_n    = pt_elt_nb(work_data_reg.wp, work_data_reg.rp);
    assign pid_sum   = {1'b0, work_data_reg.rp[BPBS_ID_W-1:0]} + {1'b0, elt_reg};

    assign ks_coef_vld   = work_vld_reg & ~reset_loop_reg;
    assign ks_coef_lwe   = work_data_reg.lwe_a[elt_reg];
    assign ks_coef_corr  = work_data_reg.corr_a[elt_reg];
    assign ks_coef_idx   = work_data_reg.ks_loop;
    assign ks_coef_pid   = (pid_sum >= BPBS_PTR_W'(BATCH_PBS_NB))
                           ? BPBS_ID_W'(pid_sum - BPBS_PTR_W'(BATCH_PBS_NB))
                           : BPBS_ID_W'(pid_sum);
    assign ks_coef_last  = ({1'b0, elt_reg} == (work_n - 1'b1));
    assign ks_coef_body  = (work_data_reg.ks_loop == KS_LOOP_W'(LWE_K_P1 - 1));
    assign ks_batch_done = done_reg & ~reset_loop_reg;

    assign accept   = ks_coef_vld & ks_coef_rdy;
    assign last_acc = accept & ks_coef_last;
    // Pull the next result in the same cycle the last element leaves; drain while flushing.
    assign fifo_rdy = reset_loop_reg | ~work_vld_reg | last_acc;
    assign load     = fifo_vld & fifo_rdy & ~reset_loop_reg;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            work_vld_reg   <= 1'b0;
            elt_reg        <= '0;
            reset_loop_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            reset_loop_reg <= reset_cache;
            done_reg       <= last_acc & ks_coef_body;
            if (reset_loop_reg) begin
                work_vld_reg <= 1'b0;
                elt_reg      <= '0;
            end else if (load) begin
                // Empty results never occupy the working register.
                work_vld_reg <= (fifo_n != '0);
                elt_reg      <= '0;
            end else if (last_acc) begin
                work_vld_reg <= 1'b0;
                elt_reg      <= '0;
            end else if (accept) begin
                elt_reg      <= elt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) work_data_reg <= fifo_data;
    end

    // ks_loop continuity tracking for the sequencing check below.
    logic [KS_LOOP_W-1:0] prev_loop_reg, exp_loop;
    logic                 loop_seen_reg;

    assign exp_loop = (prev_loop_reg == KS_LOOP_W'(LWE_K_P1 - 1)) ? '0 : prev_loop_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            loop_seen_reg <= 1'b0;
            prev_loop_reg <= '0;
        end else if (reset_loop_reg) begin
            loop_seen_reg <= 1'b0;
        end else if (load) begin
            loop_seen_reg <= 1'b1;
            prev_loop_reg <= fifo_data.ks_loop;
        end
    end

    a_elt_bound: assert property (@(posedge clk) disable iff (!s_rst_n)
        load |-> (fifo_n <= BPBS_PTR_W'(BATCH_PBS_NB)));

    a_loop_seq: assert property (@(posedge clk) disable iff (!s_rst_n)
        (load && loop_seen_reg) |-> (fifo_data.ks_loop == exp_loop));
endmodule

// File: tb/tb_pep_ks_result_dispatch.sv
// Directed bench for pep_ks_result_dispatch with immediate-assertion checks.
module tb_pep_ks_result_dispatch;
    import pep_common_param_pkg::*;
    import pep_ks_common_param_pkg::*;

    localparam int OBS_W = 1 + LWE_COEF_W + KS_MAX_ERROR_W + KS_LOOP_W + BPBS_ID_W + 2;

    logic                      clk = 1'b0;
    logic                      s_rst_n, reset_cache, seq_vld, coef_rdy;
    ks_result_t                res;
    logic [KS_RESULT_W-1:0]    seq_result;
    logic                      seq_rdy;
    logic [LWE_COEF_W-1:0]     coef_lwe;
    logic [KS_MAX_ERROR_W-1:0] coef_corr;
    logic [KS_LOOP_W-1:0]      coef_idx;
    logic [BPBS_ID_W-1:0]      coef_pid;
    logic                      coef_last, coef_body, coef_vld, batch_done;
    logic [OBS_W-1:0]          obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign seq_result = res;
    assign obs = {coef_vld, coef_lwe, coef_corr, coef_idx, coef_pid, coef_last, coef_body};

    pep_ks_result_dispatch #(.IN_FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .s_rst_n           (s_rst_n),
        .ks_seq_result     (seq_result),
        .ks_seq_result_vld (seq_vld),
        .ks_seq_result_rdy (seq_rdy),
        .reset_cache       (reset_cache),
        .ks_coef_lwe       (coef_lwe),
        .ks_coef_corr      (coef_corr),
        .ks_coef_idx       (coef_idx),
        .ks_coef_pid       (coef_pid),
        .ks_coef_last      (coef_last),
        .ks_coef_body      (coef_body),
        .ks_coef_vld       (coef_vld),
        .ks_coef_rdy       (coef_rdy),
        .ks_batch_done     (batch_done)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic ks_result_t mk(input int loop, input int rp, input int wp, input int base);
        ks_result_t r;
        r.ks_loop = KS_LOOP_W'(loop);
        r.rp      = BPBS_PTR_W'(rp);
        r.wp      = BPBS_PTR_W'(wp);
        for (int i = 0; i < BATCH_PBS_NB; i++) begin
            r.lwe_a[i]  = LWE_COEF_W'(base + i);
            r.corr_a[i] = KS_MAX_ERROR_W'((base & 8'hFF) ^ (8'hA0 + i));
        end
        return r;
    endfunction

    function automatic logic [OBS_W-1:0] ex(input int base, input int e, input int idx,
                                            input int pid, input bit last, input bit body);
        return {1'b1, LWE_COEF_W'(base + e), KS_MAX_ERROR_W'((base & 8'hFF) ^ (8'hA0 + e)),
                KS_LOOP_W'(idx), BPBS_ID_W'(pid), last, body};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input ks_result_t r);
        int budget = 0;
        res     = r;
        seq_vld = 1'b1;
        while (!seq_rdy && budget < 20) begin
            tick();
            budget++;
        end
        chk("push_rdy", seq_rdy, 1'b1);
        tick();
        seq_vld = 1'b0;
    endtask

    initial begin
        s_rst_n     = 1'b0;
        reset_cache = 1'b0;
        seq_vld     = 1'b0;
        coef_rdy    = 1'b0;
        res         = '0;
        tick(); tick();
        chk("rst_coef_vld", coef_vld, 1'b0);
        chk("rst_done", batch_done, 1'b0);
        chk("rst_in_rdy", seq_rdy, 1'b0);
        s_rst_n = 1'b1;
        tick();
        chk("post_rst_in_rdy", seq_rdy, 1'b1);
        chk("post_rst_coef_vld", coef_vld, 1'b0);

        // Basic: loop 5, rp 0, wp 3 -> pid 0,1,2 on consecutive cycles
        coef_rdy = 1'b1;
        push(mk(5, 0, 3, 16'h1100));
        chk("lat_not_yet", coef_vld, 1'b0);
        tick(); chk("t1_e0", obs, ex(16'h1100, 0, 5, 0, 0, 0));
        tick(); chk("t1_e1", obs, ex(16'h1100, 1, 5, 1, 0, 0));
        tick(); chk("t1_e2", obs, ex(16'h1100, 2, 5, 2, 1, 0));
        tick(); chk("t1_idle", coef_vld, 1'b0);
        chk("t1_no_done", batch_done, 1'b0);

        // pid wrap: rp 3, wp 5 -> pid 3 then 0
        push(mk(6, 3, 5, 16'h2200));
        tick(); chk("t2_e0", obs, ex(16'h2200, 0, 6, 3, 0, 0));
        tick(); chk("t2_e1", obs, ex(16'h2200, 1, 6, 0, 1, 0));
        tick(); chk("t2_idle", coef_vld, 1'b0);

        // Body result with stalls: loop 7, rp 1, wp 3
        coef_rdy = 1'b0;
        push(mk(7, 1, 3, 16'h3300));
        tick(); chk("t4_e0", obs, ex(16'h3300, 0, 7, 1, 0, 1));
        tick(); chk("t4_e0_hold", obs, ex(16'h3300, 0, 7, 1, 0, 1));
        coef_rdy = 1'b1;
        tick(); chk("t4_e1", obs, ex(16'h3300, 1, 7, 2, 1, 1));
        chk("t4_done_early0", batch_done, 1'b0);
        coef_rdy = 1'b0;
        tick(); chk("t4_e1_hold", obs, ex(16'h3300, 1, 7, 2, 1, 1));
        chk("t4_done_early1", batch_done, 1'b0);
        coef_rdy = 1'b1;
        tick(); chk("t4_idle", coef_vld, 1'b0);
        chk("t4_done", batch_done, 1'b1);
        tick(); chk("t4_done_pulse", batch_done, 1'b0);

        // Back-to-back n=4 results: 8 valid cycles, no bubble
        coef_rdy = 1'b0;
        push(mk(0, 0, 4, 16'h4400));
        push(mk(1, 2, 6, 16'h5500));
        coef_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) chk("t3_a", obs, ex(16'h4400, k, 0, k, k == 3, 0));
            else       chk("t3_b", obs, ex(16'h5500, k - 4, 1, (k - 2) % 4, k == 7, 0));
            tick();
        end
        chk("t3_idle", coef_vld, 1'b0);

        // n=0 result dropped, then n=1 result
        push(mk(2, 1, 1, 16'h6600));
        push(mk(3, 2, 3, 16'h7700));
        chk("t5_drop", coef_vld, 1'b0);
        tick(); chk("t5_single", obs, ex(16'h7700, 0, 3, 2, 1, 0));
        tick(); chk("t5_idle0", coef_vld, 1'b0);
        tick(); chk("t5_idle1", coef_vld, 1'b0);
        chk("t5_no_done", batch_done, 1'b0);

        // reset_cache mid-result with two queued results
        coef_rdy = 1'b0;
        push(mk(4, 0, 4, 16'h8800));
        push(mk(5, 0, 4, 16'h9900));
        push(mk(6, 0, 4, 16'hAA00));
        chk("t6_full", seq_rdy, 1'b0);
        coef_rdy = 1'b1;
        tick(); chk("t6_e1", obs, ex(16'h8800, 1, 4, 1, 0, 0));
        tick(); chk("t6_e2", obs, ex(16'h8800, 2, 4, 2, 0, 0));
        coef_rdy    = 1'b0;
        reset_cache = 1'b1;
        tick(); chk("t6_flush0", coef_vld, 1'b0);
        tick(); chk("t6_flush1", coef_vld, 1'b0);
        tick(); chk("t6_flush2", coef_vld, 1'b0);
        chk("t6_drained", seq_rdy, 1'b1);
        reset_cache = 1'b0;
        tick(); chk("t6_flush3", coef_vld, 1'b0);
        tick(); chk("t6_empty", coef_vld, 1'b0);
        chk("t6_no_done", batch_done, 1'b0);
        coef_rdy = 1'b1;
        push(mk(0, 0, 2, 16'hBB00));
        tick(); chk("t6_new_e0", obs, ex(16'hBB00, 0, 0, 0, 0, 0));
        tick(); chk("t6_new_e1", obs, ex(16'hBB00, 1, 0, 1, 1, 0));
        tick(); chk("t6_new_idle", coef_vld, 1'b0);

        // s_rst_n mid-result discards the remainder
        push(mk(1, 0, 4, 16'hCC00));
        tick(); chk("t7_e0", obs, ex(16'hCC00, 0, 1, 0, 0, 0));
        tick(); chk("t7_e1", obs, ex(16'hCC00, 1, 1, 1, 0, 0));
        s_rst_n = 1'b0;
        tick(); chk("t7_rst_vld", coef_vld, 1'b0);
        chk("t7_rst_rdy", seq_rdy, 1'b0);
        chk("t7_rst_done", batch_done, 1'b0);
        s_rst_n = 1'b1;
        tick(); chk("t7_after_vld", coef_vld, 1'b0);
        chk("t7_after_rdy", seq_rdy, 1'b1);
        tick(); chk("t7_after_vld2", coef_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
